// File: rtl/ipv_slot_if.sv
// Lane-side bundle of the IPV slot scheduler: requester handshake, reducer
// serial/result path and the tagged response.
interface ipv_slot_if #(
  parameter int K = 4,
  parameter int N = 4
);
  localparam int ID_W = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*K-1:0] req_bits;
  logic [N-1:0]   gnt;
  logic           ipv_out;
  logic [K-1:0]   vov_in;
  logic           rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [K-1:0]   rsp_vov;
  logic           busy;

  modport master (
    output req, req_bits, vov_in,
    input  gnt, ipv_out, rsp_valid, rsp_id, rsp_vov, busy
  );

  modport slave (
    input  req, req_bits, vov_in,
    output gnt, ipv_out, rsp_valid, rsp_id, rsp_vov, busy
  );
endinterface

// File: rtl/ipv_slot_scheduler.sv
// Round-robin sharing of one serial IPV reducer: grant once per K-cycle slot,
// shift the winning frame out LSB first, and tag the reducer result with the winner id.
module ipv_slot_scheduler #(
  parameter int K       = 4,
  parameter int N       = 4,
  parameter int RES_LAT = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  ipv_slot_if.slave bus
);
  localparam int ID_W = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam logic [2:0] PH_LAST = 3'(K - 1);

  logic [2:0]      phase_r;
  logic [ID_W-1:0] ptr_r;
  logic [K-1:0]    shift_r;
  logic            ipv_r;
  logic            active_r;
  logic [ID_W-1:0] act_id_r;
  logic [RES_LAT-1:0] pipe_vld_r;
  logic [ID_W-1:0] pipe_id_r [RES_LAT];

  logic            slot_end_s;
  logic            any_req_s;
  logic [N-1:0]    ge_mask_s;
  logic [N-1:0]    hi_req_s;
  logic [N-1:0]    pick_src_s;
  logic [N-1:0]    win_onehot_s;
  logic [ID_W-1:0] win_id_s;
  logic [ID_W-1:0] next_ptr_s;
  logic [K-1:0]    win_bits_s;

  assign slot_end_s = (phase_r == PH_LAST);
  assign any_req_s  = |bus.req;
  assign next_ptr_s = (win_id_s == ID_W'(N - 1)) ? {ID_W{1'b0}} : win_id_s + ID_W'(1);

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    ge_mask_s    = ~((N'(1) << ptr_r) - N'(1));
    hi_req_s     = bus.req & ge_mask_s;
    pick_src_s   = (hi_req_s != {N{1'b0}}) ? hi_req_s : bus.req;
    win_onehot_s = pick_src_s & (~pick_src_s + N'(1));
    win_id_s     = {ID_W{1'b0}};
    win_bits_s   = {K{1'b0}};
    for (int i = 0; i < N; i++) begin
      win_id_s   = win_id_s | (win_onehot_s[i] ? ID_W'(i) : {ID_W{1'b0}});
      win_bits_s = win_bits_s | (win_onehot_s[i] ? bus.req_bits[i*K +: K] : {K{1'b0}});
    end
  end

  // Free-running slot phase, in lockstep with the reducer's own slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 3'd0;
    end else begin
      phase_r <= slot_end_s ? 3'd0 : phase_r + 3'd1;
    end
  end

  // Frame capture at slot end; bit 0 goes straight to the output register so
  // phase 0 of the next slot already carries it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r    <= {ID_W{1'b0}};
      shift_r  <= {K{1'b0}};
      ipv_r    <= 1'b0;
      active_r <= 1'b0;
      act_id_r <= {ID_W{1'b0}};
    end else if (slot_end_s) begin
      active_r <= any_req_s;
      act_id_r <= win_id_s;
      ipv_r    <= win_bits_s[0];
      shift_r  <= {1'b0, win_bits_s[K-1:1]};
      ptr_r    <= any_req_s ? next_ptr_s : ptr_r;
    end else begin
      ipv_r    <= shift_r[0];
      shift_r  <= {1'b0, shift_r[K-1:1]};
    end
  end

  // Tag delay line: RES_LAT cycles matches the reducer's result latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= {RES_LAT{1'b0}};
      for (int s = 0; s < RES_LAT; s++) begin
        pipe_id_r[s] <= {ID_W{1'b0}};
      end
    end else begin
      pipe_vld_r[0] <= slot_end_s & active_r;
      pipe_id_r[0]  <= (slot_end_s & active_r) ? act_id_r : {ID_W{1'b0}};
      for (int s = 1; s < RES_LAT; s++) begin
        pipe_vld_r[s] <= pipe_vld_r[s-1];
        pipe_id_r[s]  <= pipe_id_r[s-1];
      end
    end
  end

  assign bus.gnt       = slot_end_s ? win_onehot_s : {N{1'b0}};
  assign bus.ipv_out   = ipv_r;
  assign bus.rsp_valid = pipe_vld_r[RES_LAT-1];
  assign bus.rsp_id    = pipe_vld_r[RES_LAT-1] ? pipe_id_r[RES_LAT-1] : {ID_W{1'b0}};
  assign bus.rsp_vov   = pipe_vld_r[RES_LAT-1] ? bus.vov_in : {K{1'b0}};
  assign bus.busy      = active_r | (|pipe_vld_r);
endmodule

// File: tb/tb_ipv_slot_scheduler.sv
// Directed bench for ipv_slot_scheduler with a behavioural serial IPV reducer
// (result = received frame bit-reversed, RES_LAT cycles after the slot's last bit).
module tb_ipv_slot_scheduler;
  logic clk;
  logic rst_n;
  int   cyc;
  int   vec_cnt;
  int   miss_cnt;

  ipv_slot_if #(.K(4), .N(4)) bus ();

  ipv_slot_scheduler #(.K(4), .N(4), .RES_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle 0 is the phase-0 cycle in which reset is released
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reducer model: collect the serial bits, emit reversed frame after 3 cycles.
  logic [1:0] rph;
  logic [3:0] col;
  logic [3:0] dl [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rph <= 2'd0;
      col <= 4'd0;
      for (int s = 0; s < 3; s++) dl[s] <= 4'd0;
    end else begin
      col   <= {col[2:0], bus.ipv_out};
      rph   <= rph + 2'd1;
      dl[0] <= (rph == 2'd3) ? {col[2:0], bus.ipv_out} : dl[0];
      dl[1] <= dl[0];
      dl[2] <= dl[1];
    end
  end
  assign bus.vov_in = dl[2];

  // Per-cycle log of the outputs, sampled mid-cycle.
  logic [63:0] ipv_log, busy_log, rsp_v_log, leak_log;
  logic [3:0]  gnt_log [64];
  logic [3:0]  vov_log [64];
  logic [1:0]  id_log  [64];
  always @(negedge clk) begin
    if (!rst_n) begin
      ipv_log   <= 64'd0;
      busy_log  <= 64'd0;
      rsp_v_log <= 64'd0;
      leak_log  <= 64'd0;
      for (int i = 0; i < 64; i++) begin
        gnt_log[i] <= 4'd0;
        vov_log[i] <= 4'd0;
        id_log[i]  <= 2'd0;
      end
    end else if (cyc < 64) begin
      ipv_log[cyc[5:0]]   <= bus.ipv_out;
      busy_log[cyc[5:0]]  <= bus.busy;
      rsp_v_log[cyc[5:0]] <= bus.rsp_valid;
      leak_log[cyc[5:0]]  <= !bus.rsp_valid && (bus.rsp_vov != 4'd0 || bus.rsp_id != 2'd0);
      gnt_log[cyc[5:0]]   <= bus.gnt;
      vov_log[cyc[5:0]]   <= bus.rsp_vov;
      id_log[cyc[5:0]]    <= bus.rsp_id;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic goto_cycle(input int n);
    int budget;
    budget = 100;
    while (cyc < n && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (cyc < n) check_val("goto_timeout", cyc, n);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int ones(input logic [63:0] v, input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int gnt_events(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) c += (gnt_log[i] != 4'd0) ? 1 : 0;
    return c;
  endfunction

  int       t3_gcyc [5] = '{3, 7, 11, 15, 19};
  logic [3:0] t3_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] t3_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] t3_vov [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

  initial begin
    vec_cnt      = 0;
    miss_cnt     = 0;
    rst_n        = 1'b1;
    bus.req      = 4'd0;
    bus.req_bits = 16'd0;

    // reset state
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_gnt",       bus.gnt,       4'd0);
    check_val("rst_ipv",       bus.ipv_out,   1'b0);
    check_val("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_val("rst_rsp_id",    bus.rsp_id,    2'd0);
    check_val("rst_rsp_vov",   bus.rsp_vov,   4'd0);
    check_val("rst_busy",      bus.busy,      1'b0);

    // 1: idle for 20 cycles
    rst_n = 1'b1;
    goto_cycle(21);
    check_val("t1_gnt_cnt",  gnt_events(0, 20),     0);
    check_val("t1_ipv_cnt",  ones(ipv_log, 0, 20),   0);
    check_val("t1_rsp_cnt",  ones(rsp_v_log, 0, 20), 0);
    check_val("t1_busy_cnt", ones(busy_log, 0, 20),  0);

    // 2: single frame from requester 2
    bus.req_bits = {4'b0000, 4'b0111, 4'b0000, 4'b0000};
    bus.req      = 4'b0100;
    apply_reset();
    goto_cycle(4);
    bus.req = 4'b0000;
    goto_cycle(13);
    check_val("t2_gnt3",    gnt_log[3],          4'b0100);
    check_val("t2_gnt_cnt", gnt_events(0, 12),   1);
    check_val("t2_ipv_pre", ipv_log[3:0],        4'b0000);
    check_val("t2_ipv",     ipv_log[7:4],        4'b0111);
    check_val("t2_ipv_post", ipv_log[12:8],      5'b00000);
    check_val("t2_rsp_v",   rsp_v_log[12:0],     13'h0400);
    check_val("t2_rsp_id",  id_log[10],          2'd2);
    check_val("t2_rsp_vov", vov_log[10],         4'b1110);
    check_val("t2_busy",    busy_log[12:0],      13'h07F0);

    // 3: all four requesting continuously
    bus.req_bits = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    bus.req      = 4'b1111;
    apply_reset();
    goto_cycle(20);
    bus.req = 4'b0000;
    goto_cycle(31);
    check_val("t3_gnt_cnt", gnt_events(0, 30),   5);
    check_val("t3_rsp_cnt", ones(rsp_v_log, 0, 30), 5);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("t3_gnt%0d", k),   gnt_log[t3_gcyc[k]],     t3_gnt[k]);
      check_val($sformatf("t3_rspv%0d", k),  rsp_v_log[t3_gcyc[k]+7], 1'b1);
      check_val($sformatf("t3_id%0d", k),    id_log[t3_gcyc[k]+7],    t3_id[k]);
      check_val($sformatf("t3_vov%0d", k),   vov_log[t3_gcyc[k]+7],   t3_vov[k]);
    end
    check_val("t3_busy_run", ones(busy_log, 4, 26), 23);
    check_val("t3_busy_end", busy_log[27],          1'b0);
    check_val("t3_leak",     ones(leak_log, 0, 30), 0);

    // 4: requester 1 back-to-back frames
    bus.req_bits = {4'b0000, 4'b0000, 4'b0000, 4'b0000};
    bus.req      = 4'b0010;
    apply_reset();
    goto_cycle(4);
    bus.req_bits = {4'b0000, 4'b0000, 4'b0011, 4'b0000};
    goto_cycle(8);
    bus.req = 4'b0000;
    goto_cycle(17);
    check_val("t4_gnt3",    gnt_log[3],          4'b0010);
    check_val("t4_gnt7",    gnt_log[7],          4'b0010);
    check_val("t4_gnt_cnt", gnt_events(0, 16),   2);
    check_val("t4_ipv2",    ipv_log[11:8],       4'b0011);
    check_val("t4_rsp_v",   rsp_v_log[16:0],     17'h04400);
    check_val("t4_id_a",    id_log[10],          2'd1);
    check_val("t4_vov_a",   vov_log[10],         4'b0000);
    check_val("t4_id_b",    id_log[14],          2'd1);
    check_val("t4_vov_b",   vov_log[14],         4'b1100);

    // 5: withdrawal before phase 3 leaves an idle slot and the pointer alone
    bus.req_bits = {4'b1000, 4'b0000, 4'b0000, 4'b0001};
    bus.req      = 4'b0001;
    apply_reset();
    goto_cycle(4);
    bus.req = 4'b1000;
    goto_cycle(6);
    bus.req = 4'b0000;
    goto_cycle(8);
    bus.req = 4'b1001;
    goto_cycle(12);
    bus.req = 4'b0001;
    goto_cycle(16);
    bus.req = 4'b0000;
    goto_cycle(27);
    check_val("t5_gnt3",    gnt_log[3],          4'b0001);
    check_val("t5_gnt7",    gnt_log[7],          4'b0000);
    check_val("t5_gnt11",   gnt_log[11],         4'b1000);
    check_val("t5_gnt15",   gnt_log[15],         4'b0001);
    check_val("t5_gnt_cnt", gnt_events(0, 26),   3);
    check_val("t5_idle_ipv", ipv_log[11:8],      4'b0000);
    check_val("t5_idle_busy", busy_log[11],      1'b0);
    check_val("t5_rsp_v",   rsp_v_log[26:0],     27'h0440400);
    check_val("t5_id18",    id_log[18],          2'd3);
    check_val("t5_vov18",   vov_log[18],         4'b0001);
    check_val("t5_id22",    id_log[22],          2'd0);
    check_val("t5_vov22",   vov_log[22],         4'b1000);
    check_val("t5_leak",    ones(leak_log, 0, 26), 0);

    // 6: reset two cycles after a grant discards the in-flight frame
    bus.req_bits = {4'b0000, 4'b0111, 4'b0011, 4'b0000};
    bus.req      = 4'b0100;
    apply_reset();
    goto_cycle(4);
    bus.req = 4'b0000;
    goto_cycle(5);
    check_val("t6_pre_ipv",  bus.ipv_out, 1'b1);
    check_val("t6_pre_busy", bus.busy,    1'b1);
    rst_n = 1'b0;
    #1;
    check_val("t6_gnt",       bus.gnt,       4'd0);
    check_val("t6_ipv",       bus.ipv_out,   1'b0);
    check_val("t6_rsp_valid", bus.rsp_valid, 1'b0);
    check_val("t6_rsp_vov",   bus.rsp_vov,   4'd0);
    check_val("t6_busy",      bus.busy,      1'b0);
    bus.req = 4'b0010;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    goto_cycle(4);
    bus.req = 4'b0000;
    goto_cycle(14);
    check_val("t6_gnt3",    gnt_log[3],            4'b0010);
    check_val("t6_gnt_cnt", gnt_events(0, 13),     1);
    check_val("t6_rsp_cnt", ones(rsp_v_log, 0, 13), 1);
    check_val("t6_rsp_v10", rsp_v_log[10],         1'b1);
    check_val("t6_id10",    id_log[10],            2'd1);
    check_val("t6_vov10",   vov_log[10],           4'b1100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
